instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
- Responder end of the instruction-memory interface driven by the fetch stage.
- Word-addressed synchronous SRAM model: 2048 x 32, active-low chip, write and output enables, 1-cycle registered read.
- Built-in power-on clear sequencer that zero-fills the array after reset and raises `ready` when done.
- Sits between the fetch stage (reads) and the program loader / testbench (writes).

Parameters:
- ADDR_W, 11, address width in words.
- DATA_W, 32, data word width.
- DEPTH, 2048, number of words; must be <= 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- im_cen  input  1  chip enable, active low.
- im_wen  input  1  write enable, active low; 1 = read.
- im_oen  input  1  output enable, active low.
- im_addr  input  ADDR_W  word address.
- im_datain  input  DATA_W  write data.
- im_dataout  output  DATA_W  read data.
- ready  output  1  high once the clear sequence is complete.
- parity_err  output  1  parity mismatch on the last read.

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT, clear counter=0, ready=0.
  - Read register = 0, parity_err=0.
  - Array contents are not reset directly; the clear sequence handles them.
- INIT state: one word per cycle, mem[cnt] <= 0 and cnt <= cnt+1.
  - The write in which cnt == DEPTH-1 is the last; the next state is READY.
  - ready rises on the edge after the last clear write: DEPTH cycles after reset release.
  - All im_* requests are ignored in INIT; the read register stays 0.
- READY state, sampled each rising edge:
  - cen=0, wen=0: mem[addr] <= datain; read register holds (no write-through).
  - cen=0, wen=1: read register <= mem[addr]; 1-cycle latency.
  - cen=1: no access; read register holds.
- Address at or above DEPTH (only possible when DEPTH < 2**ADDR_W):
  - Write is dropped.
  - Read loads 0 into the read register.
- Read/write to the same address on consecutive cycles: the read returns the new data; no hazard.
- Output: im_dataout = (im_oen==0) ? read register : 0, combinational on im_oen.
- Async reset during INIT or READY restarts the full clear sequence; ready drops immediately.
- ready never falls except on reset.

Optional Feature:
- IM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed from im_datain on write; the clear sequence writes parity 0.
  - On a read, parity_err is registered alongside the read data: 1 when the XOR of the stored data and the stored parity bit is 1.
  - parity_err holds when no read occurs and resets to 0.
- Undefined: no parity storage; parity_err tied to 0.

Decomposition:
- Shared package im_pkg holds:
  - ADDR_W and DATA_W defaults.
  - UNDEFINE constant (all zeros).
  - State typedef {INIT, READY}.
  - Access-decode constants, e.g. CEN_ACTIVE=0, WEN_WRITE=0.
- Sub-module im_array: storage plus registered read port with parity, muxed write port.
- Top: clear sequencer FSM, write-port mux (clear vs. user), output gating.

Test Plan:
- Reset release, requests held idle -> ready=0 for 2047 cycles, ready=1 after exactly 2048 cycles; read of addr 0x7FF returns 0x00000000.
- Write 0xDEADBEEF to 0x005, then read 0x005 with oen=0 -> im_dataout=0xDEADBEEF one cycle after the read edge; with oen=1 -> 0x00000000.
- Back-to-back reads 0x000..0x003 after writing 1,2,3,4 -> outputs 1,2,3,4 on consecutive cycles; cen=1 next cycle -> output holds 4.
- Write request (addr 0x010, 0x12345678) during INIT, then read 0x010 after ready -> 0x00000000.
- Assert rst_n=0 mid-READY, then release -> ready=0 immediately, output 0, previously written 0xDEADBEEF at 0x005 reads 0 after the new clear.
- IM_PARITY_EN: force a stored data bit flip via hierarchical deposit at 0x020, then read -> parity_err=1; normal read of 0x005 -> parity_err=0.

Source files
------------

// File: rtl/im_pkg.sv
// Shared definitions for the instruction memory slice.
// Optional feature macro: IM_PARITY_EN (per-word even parity with read-side check).
package im_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 2048;

    // Value driven on data paths that carry nothing meaningful.
    localparam logic [DATA_W_DEF-1:0] UNDEFINE = '0;

    // Active-low access decode levels.
    localparam logic CEN_ACTIVE = 1'b0;
    localparam logic WEN_WRITE  = 1'b0;
    localparam logic OEN_ACTIVE = 1'b0;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/im_array.sv
// Word storage with a single muxed write port and a registered read port.
// Optional feature macro: IM_PARITY_EN (stores an even-parity bit per word).
module im_array
    import im_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              parity_err
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              w_ok;
    logic              r_ok;

    // Addresses past the populated depth drop writes and read as zero.
    assign w_ok = ({1'b0, waddr} < DEPTH_W);
    assign r_ok = ({1'b0, raddr} < DEPTH_W);

    // Array write; contents are not reset, the clear sequencer fills them.
    always_ff @(posedge clk) begin
        if (we && w_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read data, holds whenever no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_ok ? mem[raddr] : '0;
        end
    end

`ifdef IM_PARITY_EN
    logic par [DEPTH];

    // Parity bit write alongside the data word (zero data gives parity 0).
    always_ff @(posedge clk) begin
        if (we && w_ok) begin
            par[waddr] <= ^wdata;
        end
    end

    // Parity check registered together with the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (re) begin
            parity_err <= r_ok ? ((^mem[raddr]) ^ par[raddr]) : 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory responder: power-on clear sequencer, write-port mux and
// output-enable gating around the im_array storage.
// Optional feature macro: IM_PARITY_EN (forwarded to im_array).
module instruction_memory
    import im_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              im_cen,
    input  logic              im_wen,
    input  logic              im_oen,
    input  logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_datain,
    output logic [DATA_W-1:0] im_dataout,
    output logic              ready,
    output logic              parity_err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic [DATA_W-1:0] rdata;

    // Sequencer state and clear counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next state, clear-vs-user write port mux and read request decode.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        we         = 1'b0;
        waddr      = im_addr;
        wdata      = im_datain;
        re         = 1'b0;
        if (state == INIT) begin
            we       = 1'b1;
            waddr    = cnt;
            wdata    = DATA_W'(UNDEFINE);
            cnt_next = cnt + ADDR_W'(1);
            if (cnt == LAST) begin
                next_state = READY;
                cnt_next   = '0;
            end
        end else begin
            we = (im_cen == CEN_ACTIVE) && (im_wen == WEN_WRITE);
            re = (im_cen == CEN_ACTIVE) && (im_wen != WEN_WRITE);
        end
    end

    im_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .re         (re),
        .raddr      (im_addr),
        .rdata      (rdata),
        .parity_err (parity_err)
    );

    assign ready      = (state == READY);
    assign im_dataout = (im_oen == OEN_ACTIVE) ? rdata : DATA_W'(UNDEFINE);

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory against an array-based reference.
// Optional feature macro: IM_PARITY_EN (enables the parity scenario).
module tb_instruction_memory;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;

    logic              clk;
    logic              rst_n;
    logic              im_cen;
    logic              im_wen;
    logic              im_oen;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_datain;
    logic [DATA_W-1:0] im_dataout;
    logic              ready;
    logic              parity_err;

    int errors = 0;
    int checks = 0;

    // Reference: memory contents and the last value returned by a read.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] ref_rd;

    instruction_memory #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .im_cen     (im_cen),
        .im_wen     (im_wen),
        .im_oen     (im_oen),
        .im_addr    (im_addr),
        .im_datain  (im_datain),
        .im_dataout (im_dataout),
        .ready      (ready),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        im_cen    = 1'b1;
        im_wen    = 1'b1;
        im_addr   = '0;
        im_datain = '0;
    endtask

    task automatic ref_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_rd = '0;
    endtask

    // Waits (bounded) for ready; returns cycles counted from the call.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 3000) begin
            tick();
            cycles++;
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        im_cen = 1'b0; im_wen = 1'b0; im_addr = a; im_datain = d;
        tick();
        ref_mem[a] = d;
        idle();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        im_cen = 1'b0; im_wen = 1'b1; im_addr = a;
        tick();
        ref_rd = ref_mem[a];
        idle();
    endtask

    task automatic reset_and_clear(input string tag);
        int cyc;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        ref_clear();
        wait_ready(cyc);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: ready=%b after %0d cycles, required 1", tag, ready, cyc);
        end
    endtask

    task automatic test_reset();
        int cyc;
        idle();
        im_oen = 1'b0;
        rst_n  = 1'b0;
        repeat (2) tick();
        checks++;
        if (ready !== 1'b0 || im_dataout !== 32'h0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b dataout=%h perr=%b, required 0/00000000/0",
                     ready, im_dataout, parity_err);
        end
        rst_n = 1'b1;
        ref_clear();
        wait_ready(cyc);
        checks++;
        if (cyc != DEPTH) begin
            errors++;
            $display("FAIL clear_latency: ready after %0d cycles, required %0d", cyc, DEPTH);
        end
        do_read(11'h7FF);
        checks++;
        if (im_dataout !== 32'h0) begin
            errors++;
            $display("FAIL read_7ff_cleared: got %h, required 00000000", im_dataout);
        end
    endtask

    task automatic test_write_read_oen();
        do_write(11'h005, 32'hDEADBEEF);
        im_oen = 1'b0;
        do_read(11'h005);
        checks++;
        if (im_dataout !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_005_oen0: got %h, required deadbeef", im_dataout);
        end
        im_oen = 1'b1;
        #1;
        checks++;
        if (im_dataout !== 32'h0) begin
            errors++;
            $display("FAIL read_005_oen1: got %h, required 00000000", im_dataout);
        end
        im_oen = 1'b0;
        #1;
        checks++;
        if (im_dataout !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL oen_reenable: got %h, required deadbeef", im_dataout);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp;
        for (int i = 0; i < 4; i++) do_write(ADDR_W'(i), DATA_W'(i + 1));
        im_oen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            im_cen = 1'b0; im_wen = 1'b1; im_addr = ADDR_W'(i);
            tick();
            exp = DATA_W'(i + 1);
            checks++;
            if (im_dataout !== exp) begin
                errors++;
                $display("FAIL b2b_read_%0d: got %h, required %h", i, im_dataout, exp);
            end
        end
        idle();
        tick();
        checks++;
        if (im_dataout !== 32'h4) begin
            errors++;
            $display("FAIL b2b_hold: got %h, required 00000004", im_dataout);
        end
        // Write immediately followed by a read of the same address.
        im_cen = 1'b0; im_wen = 1'b0; im_addr = 11'h100; im_datain = 32'hA5A5_0F0F;
        tick();
        checks++;
        if (im_dataout !== 32'h4) begin
            errors++;
            $display("FAIL write_no_passthru: got %h, required 00000004", im_dataout);
        end
        im_wen = 1'b1;
        tick();
        idle();
        ref_mem[11'h100] = 32'hA5A5_0F0F;
        checks++;
        if (im_dataout !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL wr_then_rd: got %h, required a5a50f0f", im_dataout);
        end
    endtask

    task automatic test_init_ignored();
        int cyc;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        ref_clear();
        im_oen = 1'b0;
        im_cen = 1'b0; im_wen = 1'b0; im_addr = 11'h010; im_datain = 32'h12345678;
        repeat (50) tick();
        im_wen = 1'b1;
        repeat (20) tick();
        checks++;
        if (im_dataout !== 32'h0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL init_read_ignored: dataout=%h ready=%b, required 00000000/0", im_dataout, ready);
        end
        // Late-INIT write to a word the sequencer has already cleared.
        im_wen = 1'b0; im_addr = 11'h011; im_datain = 32'hCAFE_F00D;
        repeat (10) tick();
        idle();
        wait_ready(cyc);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL init_ready_timeout: ready=%b, required 1", ready);
        end
        do_read(11'h010);
        checks++;
        if (im_dataout !== 32'h0) begin
            errors++;
            $display("FAIL init_write_010_dropped: got %h, required 00000000", im_dataout);
        end
        do_read(11'h011);
        checks++;
        if (im_dataout !== 32'h0) begin
            errors++;
            $display("FAIL init_write_011_dropped: got %h, required 00000000", im_dataout);
        end
    endtask

    task automatic test_reset_mid_ready();
        do_write(11'h005, 32'hDEADBEEF);
        im_oen = 1'b0;
        do_read(11'h005);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || im_dataout !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ready=%b dataout=%h, required 0/00000000", ready, im_dataout);
        end
        #1;
        reset_and_clear("mid");
        do_read(11'h005);
        checks++;
        if (im_dataout !== 32'h0) begin
            errors++;
            $display("FAIL reclear_005: got %h, required 00000000", im_dataout);
        end
    endtask

    task automatic test_random();
        int n_err = 0;
        logic [DATA_W-1:0] exp;
        logic [ADDR_W-1:0] a;
        int op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 2);
            a  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 31));
            im_oen = ($urandom_range(0, 3) == 0);
            im_addr = a;
            im_datain = $urandom;
            im_cen = (op == 2);
            im_wen = (op != 0);
            tick();
            if (op == 0) ref_mem[a] = im_datain;
            else if (op == 1) ref_rd = ref_mem[a];
            exp = im_oen ? 32'h0 : ref_rd;
            checks++;
            if (im_dataout !== exp) begin
                errors++;
                n_err++;
                if (n_err < 10)
                    $display("FAIL random_%0d: addr=%h dataout=%h, required %h", i, a, im_dataout, exp);
            end
`ifndef IM_PARITY_EN
            if ((i % 50) == 0) begin
                checks++;
                if (parity_err !== 1'b0) begin
                    errors++;
                    $display("FAIL parity_tied_low: got %b, required 0", parity_err);
                end
            end
`endif
        end
        idle();
        im_oen = 1'b0;
    endtask

`ifdef IM_PARITY_EN
    task automatic test_parity();
        do_write(11'h020, 32'h0000_00F0);
        do_write(11'h005, 32'hDEADBEEF);
        dut.u_array.mem[32] = dut.u_array.mem[32] ^ 32'h0000_0100;
        do_read(11'h020);
        checks++;
        if (parity_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_flip_detect: got %b, required 1", parity_err);
        end
        idle();
        tick();
        checks++;
        if (parity_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_hold: got %b, required 1", parity_err);
        end
        do_read(11'h005);
        checks++;
        if (parity_err !== 1'b0 || im_dataout !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL parity_clean_read: perr=%b dataout=%h, required 0/deadbeef", parity_err, im_dataout);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        im_oen = 1'b0;
        idle();
        test_reset();
        test_write_read_oen();
        test_back_to_back();
        test_init_ignored();
        test_reset_mid_ready();
        test_random();
`ifdef IM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
